// File: rtl/digital_tube.sv
// Eight-digit multiplexed seven-segment driver with a DATA/CTRL register port.
// DATA is copied to a shadow register once per scan frame so a frame never shows a torn update.
module digital_tube #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic [7:0]  seg_n,
  output logic [7:0]  sel_n
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_LIM = DW'(BLANK_CYC);

  logic [31:0]   data_q,   data_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [15:0]   ctrl_q,   ctrl_d;
  logic [DW-1:0] div_q,    div_d;
  logic [2:0]    idx_q,    idx_d;
  logic [7:0]    seg_n_q,  seg_n_d;
  logic [7:0]    sel_n_q,  sel_n_d;

  logic          div_wrap;
  logic          blank;
  logic [3:0]    digit [8];

  function automatic logic [7:0] decode(input logic [3:0] hex);
    logic [7:0] seg;
    case (hex)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign digit[gi] = shadow_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (WE) begin
      if (Addr) ctrl_d = WD[15:0];
      else      data_d = WD;
    end

    div_wrap = (div_q == DIV_MAX);
    div_d    = div_wrap ? '0 : div_q + DW'(1);
    idx_d    = div_wrap ? idx_q + 3'd1 : idx_q;

    // Shadow samples the pre-write DATA on the 7->0 wrap, so a colliding write shows a frame later.
    shadow_d = (div_wrap && (idx_q == 3'd7)) ? data_q : shadow_q;

    blank   = (div_q < BLANK_LIM);
    sel_n_d = 8'hFF;
    seg_n_d = 8'hFF;
    if (!blank) begin
      if (ctrl_q[idx_q]) sel_n_d = ~(8'h01 << idx_q);
      seg_n_d = decode(digit[idx_q]);
      if (ctrl_q[{1'b1, idx_q}]) seg_n_d[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      shadow_q <= '0;
      ctrl_q   <= 16'h00FF;
      div_q    <= '0;
      idx_q    <= '0;
      seg_n_q  <= 8'hFF;
      sel_n_q  <= 8'hFF;
    end else begin
      data_q   <= data_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_n_q  <= seg_n_d;
      sel_n_q  <= sel_n_d;
    end
  end

  assign RD    = Addr ? {16'h0000, ctrl_q} : data_q;
  assign seg_n = seg_n_q;
  assign sel_n = sel_n_q;

endmodule
